// File: rtl/led_seq_pkg.sv
// Shared phase/mode types, finale position table and phase-ordering helpers
// for the LED pattern sequencer.
package led_seq_pkg;

  typedef enum logic [3:0] {
    PH_IDLE    = 4'd0,
    PH_FILL    = 4'd1,
    PH_DRAIN   = 4'd2,
    PH_SWEEP_R = 4'd3,
    PH_SWEEP_L = 4'd4,
    PH_GAP     = 4'd5,
    PH_BLINK   = 4'd6,
    PH_HALVES  = 4'd7,
    PH_FINALE  = 4'd8
  } phase_e;

  typedef enum logic [1:0] {
    MODE_FULL   = 2'd0,
    MODE_SWEEP  = 2'd1,
    MODE_BLINK  = 2'd2,
    MODE_FREEZE = 2'd3
  } mode_e;

  localparam int K_W     = 8;
  localparam int FIN_LEN = 5;
  localparam logic [7:0] FIN_TAB [FIN_LEN] = '{8'd2, 8'd6, 8'd0, 8'd3, 8'd5};

  // Nine phases share a 3-bit output code: the two dark single-step phases (IDLE, GAP) both report 0.
  function automatic logic [2:0] phase_code(input phase_e ph);
    case (ph)
      PH_FILL:    return 3'd1;
      PH_DRAIN:   return 3'd2;
      PH_SWEEP_R: return 3'd3;
      PH_SWEEP_L: return 3'd4;
      PH_BLINK:   return 3'd5;
      PH_HALVES:  return 3'd6;
      PH_FINALE:  return 3'd7;
      default:    return 3'd0;
    endcase
  endfunction

  function automatic phase_e first_phase(input mode_e m);
    case (m)
      MODE_SWEEP: return PH_SWEEP_R;
      MODE_BLINK: return PH_BLINK;
      default:    return PH_IDLE;
    endcase
  endfunction

  function automatic phase_e last_phase(input mode_e m);
    case (m)
      MODE_SWEEP: return PH_SWEEP_L;
      MODE_BLINK: return PH_BLINK;
      default:    return PH_FINALE;
    endcase
  endfunction

  function automatic phase_e next_phase(input mode_e m, input phase_e ph);
    if (m == MODE_SWEEP) begin
      return (ph == PH_SWEEP_R) ? PH_SWEEP_L : PH_SWEEP_R;
    end else if (m == MODE_BLINK) begin
      return PH_BLINK;
    end else begin
      case (ph)
        PH_IDLE:    return PH_FILL;
        PH_FILL:    return PH_DRAIN;
        PH_DRAIN:   return PH_SWEEP_R;
        PH_SWEEP_R: return PH_SWEEP_L;
        PH_SWEEP_L: return PH_GAP;
        PH_GAP:     return PH_BLINK;
        PH_BLINK:   return PH_HALVES;
        PH_HALVES:  return PH_FINALE;
        default:    return PH_IDLE;
      endcase
    end
  endfunction

endpackage

// File: rtl/led_seq_prescaler.sv
// Free-running prescaler with a selectable tap; emits a one-cycle tick on each
// 0->1 transition of the tap bit, all in the single clock domain.
module led_seq_prescaler
  import led_seq_pkg::*;
#(
  parameter int DIV_W    = 26,
  parameter int BASE_TAP = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [2:0] i_rate_sel,
  output logic       o_tick
);

  localparam int TAP_W = $clog2(DIV_W);

  if (BASE_TAP + 7 >= DIV_W) begin : g_tap_check
    $error("led_seq_prescaler: BASE_TAP+7 must be below DIV_W");
  end

  logic [DIV_W-1:0] r_cnt;
  logic             r_tap_d;
  logic [TAP_W-1:0] w_tap;
  logic             w_tap_bit;

  // Tap follows rate_sel live; comparing against last cycle's tap bit keeps every pulse one cycle wide.
  always_comb begin
    w_tap     = TAP_W'(BASE_TAP) + TAP_W'(i_rate_sel);
    w_tap_bit = r_cnt[w_tap];
  end

  assign o_tick = w_tap_bit & ~r_tap_d;

  // Counter and tap history.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt   <= {DIV_W{1'b0}};
      r_tap_d <= 1'b0;
    end else begin
      r_cnt   <= r_cnt + DIV_W'(1);
      r_tap_d <= w_tap_bit;
    end
  end

endmodule

// File: rtl/led_pattern_seq.sv
// LED pattern sequencer: phase/step FSM stepped by the prescaler tick (or by
// step pulses while frozen), with combinational pattern decode into the LED register.
module led_pattern_seq
  import led_seq_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DIV_W    = 26,
  parameter int BASE_TAP = 4,
  parameter int BLINK_N  = 21,
  parameter int HALF_N   = 17,
  parameter int FIN_N    = 33
) (
  input  logic             clk25,
  input  logic             rst_n,
  input  logic [2:0]       rate_sel,
  input  logic [1:0]       mode,
  input  logic             step,
  output logic [WIDTH-1:0] leds,
  output logic [2:0]       phase,
  output logic             frame_done
);

  if ((WIDTH % 2) != 0 || WIDTH < 4 || WIDTH > 32 || BLINK_N < 1 || HALF_N < 1 ||
      FIN_N < 1 || BLINK_N > 255 || HALF_N > 255 || FIN_N > 255) begin : g_param_check
    $error("led_pattern_seq: WIDTH must be even in 4..32 and step counts in 1..255");
  end

  localparam logic [WIDTH-1:0] ZEROS    = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES     = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] LOW_HALF = {{(WIDTH/2){1'b0}}, {(WIDTH/2){1'b1}}};
  localparam logic [K_W-1:0]   TOP_IDX  = K_W'(WIDTH - 1);

  function automatic logic [K_W-1:0] phase_len(input phase_e ph);
    case (ph)
      PH_FILL, PH_SWEEP_R, PH_SWEEP_L: return K_W'(WIDTH);
      PH_DRAIN:  return K_W'(WIDTH + 1);
      PH_BLINK:  return K_W'(BLINK_N);
      PH_HALVES: return K_W'(HALF_N);
      PH_FINALE: return K_W'(FIN_N);
      default:   return K_W'(1);
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] pattern(input phase_e ph, input logic [K_W-1:0] k);
    logic [2:0]     fin_idx;
    logic [K_W-1:0] fin_pos;
    fin_idx = 3'((k >> 1) % K_W'(FIN_LEN));
    fin_pos = K_W'(FIN_TAB[fin_idx] % 8'(WIDTH));
    case (ph)
      PH_FILL:    return ~(ONES >> (k + K_W'(1)));
      PH_DRAIN:   return ONES << k;
      PH_SWEEP_R: return ONE << (TOP_IDX - k);
      PH_SWEEP_L: return ONE << k;
      PH_BLINK:   return k[0] ? ZEROS : ONES;
      PH_HALVES:  return k[0] ? ~LOW_HALF : LOW_HALF;
      PH_FINALE:  return k[0] ? ZEROS : (ONE << (TOP_IDX - fin_pos));
      default:    return ZEROS;
    endcase
  endfunction

  logic             w_tick;
  logic             w_frozen;
  logic             w_exit;
  logic             w_step_rise;
  logic             w_adv;
  logic             w_wrap;
  phase_e           w_phase_nxt;
  logic [K_W-1:0]   w_k_nxt;
  logic             w_restart_nxt;
  mode_e            w_mode_nxt;
  logic [WIDTH-1:0] w_leds_nxt;

  phase_e           r_phase;
  logic [K_W-1:0]   r_k;
  logic             r_restart;
  mode_e            r_active_mode;
  logic [WIDTH-1:0] r_leds;
  logic             r_frame_done;
  logic             r_step_d;
  logic             r_frozen_d;

  led_seq_prescaler #(
    .DIV_W    (DIV_W),
    .BASE_TAP (BASE_TAP)
  ) u_prescaler (
    .i_clk      (clk25),
    .i_rst_n    (rst_n),
    .i_rate_sel (rate_sel),
    .o_tick     (w_tick)
  );

  // Next-state: r_restart marks "next advance enters the first phase of the latched mode".
  always_comb begin
    w_frozen      = (mode_e'(mode) == MODE_FREEZE);
    w_exit        = r_frozen_d & ~w_frozen;
    w_step_rise   = step & ~r_step_d;
    w_adv         = w_frozen ? w_step_rise : (w_tick & ~w_exit);
    w_wrap        = 1'b0;
    w_phase_nxt   = r_phase;
    w_k_nxt       = r_k;
    w_restart_nxt = r_restart;
    w_mode_nxt    = r_active_mode;
    w_leds_nxt    = r_leds;
    if (w_exit) begin
      w_mode_nxt    = mode_e'(mode);
      w_restart_nxt = 1'b1;
    end else if (w_adv) begin
      if (r_restart) begin
        w_phase_nxt   = first_phase(r_active_mode);
        w_k_nxt       = {K_W{1'b0}};
        w_restart_nxt = 1'b0;
      end else if (r_k == phase_len(r_phase) - K_W'(1)) begin
        w_k_nxt = {K_W{1'b0}};
        if (r_phase == last_phase(r_active_mode)) begin
          w_wrap = 1'b1;
          if (!w_frozen) begin
            w_mode_nxt = mode_e'(mode);
          end else begin
            w_mode_nxt = r_active_mode;
          end
          w_phase_nxt = first_phase(w_mode_nxt);
        end else begin
          w_phase_nxt = next_phase(r_active_mode, r_phase);
        end
      end else begin
        w_k_nxt = r_k + K_W'(1);
      end
      w_leds_nxt = pattern(w_phase_nxt, w_k_nxt);
    end else begin
      w_wrap = 1'b0;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      r_phase       <= PH_IDLE;
      r_k           <= {K_W{1'b0}};
      r_restart     <= 1'b1;
      r_active_mode <= MODE_FULL;
      r_leds        <= ZEROS;
      r_frame_done  <= 1'b0;
      r_step_d      <= 1'b0;
      r_frozen_d    <= 1'b0;
    end else begin
      r_phase       <= w_phase_nxt;
      r_k           <= w_k_nxt;
      r_restart     <= w_restart_nxt;
      r_active_mode <= w_mode_nxt;
      r_leds        <= w_leds_nxt;
      r_frame_done  <= w_wrap;
      r_step_d      <= step;
      r_frozen_d    <= w_frozen;
    end
  end

  assign leds       = r_leds;
  assign phase      = phase_code(r_phase);
  assign frame_done = r_frame_done;

endmodule

// File: doc/led_pattern_seq.md
LED_PATTERN_SEQ -- requirements
Module: led_pattern_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: LED count, even, 4..32.
REQ-002 The block SHALL have parameter DIV_W, default 26: prescaler counter width.
REQ-003 The block SHALL have parameter BASE_TAP, default 4: prescaler bit selected when rate_sel=0; BASE_TAP+7 SHALL be less than DIV_W, enforced by an elaboration-time check.
REQ-004 The block SHALL have parameters BLINK_N, default 21; HALF_N, default 17; FIN_N, default 33: step counts of the BLINK, HALVES and FINALE phases.
REQ-005 The block SHALL have input clk25, 1 bit: the single clock, rising edge.
REQ-006 The block SHALL have input rst_n, 1 bit: asynchronous reset, active low.
REQ-007 The block SHALL have input rate_sel, 3 bits: step-rate select.
REQ-008 The block SHALL have input mode, 2 bits: 0 full show, 1 sweep loop, 2 blink loop, 3 freeze.
REQ-009 The block SHALL have input step, 1 bit: single-step request, honoured only in freeze.
REQ-010 The block SHALL have output leds, WIDTH bits: registered LED pattern.
REQ-011 The block SHALL have output phase, 3 bits: current phase encoding.
REQ-012 The block SHALL have output frame_done, 1 bit: one-cycle pulse at frame wrap.

Function
REQ-013 The prescaler SHALL be a free-running DIV_W-bit counter incremented every clk25 cycle; tap = BASE_TAP+rate_sel.
REQ-014 tick SHALL be a one-cycle pulse on the 0->1 transition of the tap bit, detected synchronously in clk25, with no derived clocks; tick period SHALL be 2^(tap+1) cycles.
REQ-015 A rate_sel change SHALL take effect at the next tap transition; a spurious tick at the change is permitted, a missing or double-width pulse is not.
REQ-016 Phases SHALL be IDLE, FILL, DRAIN, SWEEP_R, SWEEP_L, GAP, BLINK, HALVES, FINALE; step index k SHALL reset to 0 on every phase entry.
REQ-017 Step patterns and lengths SHALL be:
- IDLE: 1 step, all zeros.
- FILL: WIDTH steps, top k+1 bits set.
- DRAIN: WIDTH+1 steps, all-ones << k.
- SWEEP_R: WIDTH steps, one-hot at bit WIDTH-1-k.
- SWEEP_L: WIDTH steps, one-hot at bit k.
- GAP: 1 step, zeros.
- BLINK: BLINK_N steps; even k all ones, odd k zeros.
- HALVES: HALF_N steps; even k low half set, odd k high half set.
- FINALE: FIN_N steps; odd k zeros; even k one-hot at bit WIDTH-1-pos, with pos = FIN_TAB[(k/2) mod 5] mod WIDTH and FIN_TAB = {2,6,0,3,5}.
REQ-018 Mode 0 order SHALL be IDLE..FINALE, then wrap to IDLE; mode 1 SHALL loop SWEEP_R, SWEEP_L; mode 2 SHALL loop BLINK.
REQ-019 A frame wrap SHALL be the step leaving the last phase of the active loop; frame_done SHALL pulse in the cycle leds takes the first step of the new frame.
REQ-020 Modes 0-2 SHALL be latched into active_mode only at frame wrap and on exit from freeze; exit from freeze SHALL restart at the first phase of the new mode with k=0.
REQ-021 Live mode==3 SHALL freeze immediately: ticks are ignored and leds holds; each rising edge of step SHALL advance exactly one step in active_mode order.
REQ-022 On each tick while not frozen, the block SHALL advance one step; leds SHALL show the new pattern exactly 1 clk25 cycle after the tick.
REQ-023 phase SHALL change in the same cycle as leds.

Reset
REQ-024 While rst_n is low, prescaler, k, tap history and step history SHALL be 0.
REQ-025 While rst_n is low, phase SHALL be IDLE, active_mode 0, leds 0 and frame_done 0.
REQ-026 Reset asserted mid-frame SHALL clear all state asynchronously; after deassertion the first tick SHALL enter the first phase of the latched mode.

Structure
REQ-027 Package led_seq_pkg SHALL hold the phase enum, mode encodings, FIN_TAB and the table length 5.
REQ-028 The prescaler and tick detector SHALL be sub-module led_seq_prescaler (DIV_W, BASE_TAP).
REQ-029 The sequencer FSM and pattern decode SHALL live in the top module; decode SHALL be combinational into the leds register.

Verification (WIDTH=8, rate_sel=0, tick every 32 cycles)
REQ-030 Reset, then mode 0: leds = 00, 80, C0 ... FF (FILL), then FF, FE ... 00 (DRAIN), each change 1 cycle after tick.
REQ-031 After SWEEP_L: GAP = 00; BLINK = FF, 00 alternating for 21 steps; HALVES = 0F, F0 for 17 steps.
REQ-032 FINALE even steps = 20, 02, 80, 10, 04, repeating; odd steps = 00; frame_done pulses once on return to IDLE.
REQ-033 Switch mode 0->1 at mid-BLINK: no effect until wrap; then 80, 40 ... 01, 01, 02 ... 80 repeating.
REQ-034 Mode 3 at mid-FILL: leds hold through 10 ticks; 3 step pulses advance exactly 3 steps; rate_sel 0->7 gives tick period 4096.
REQ-035 rst_n low mid-DRAIN: leds = 00 within the same cycle; no frame_done pulse.
